apd_hv_dac_spi: RTL and testbench



---
 rtl/apd_hv_dac_spi.sv | 152 +++++++++++++++
 tb/tb_apd_hv_dac_spi.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apd_hv_dac_spi.sv
// Serial write engine for the APD high-voltage DAC.
// A word is shifted MSB-first over a 3-wire SPI link (cs_n, sclk, din).
// Requests that arrive while a frame is in flight go into a one-deep
// "latest wins" pending slot, which is sent once the link is free.
module apd_hv_dac_spi #(
    parameter int unsigned SCLK_HALF = 10,
    parameter int unsigned CS_SETUP  = 4,
    parameter int unsigned CS_HOLD   = 4,
    parameter int unsigned CS_GAP    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  logic [15:0] da_count,
    output logic        busy,
    output logic        done,
    output logic [15:0] last_word,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  ovr_cnt,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_din
);

    localparam int unsigned TW = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t      state;
    logic [TW-1:0] tmr;
    logic [15:0] shreg;
    logic [3:0]  bitcnt;
    logic        pend_valid;
    logic [15:0] pend_word;

    logic        gap_last;
    logic        start;
    logic [15:0] start_word;

    // Frame-start decision: a new request in IDLE, or the final GAP cycle
    // with either a fresh request (which beats the pending slot) or a pending word.
    always_comb begin
        gap_last   = (state == GAP) && (tmr == '0);
        start      = ((state == IDLE) && set_en) ||
                     (gap_last && (set_en || pend_valid));
        start_word = set_en ? da_count : pend_word;
    end

    // Frame sequencer, pending slot and status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            pend_valid <= 1'b0;
            pend_word  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            last_word  <= '0;
            frame_cnt  <= '0;
            ovr_cnt    <= '0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b1;
            dac_din    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg      <= start_word;
                dac_cs_n   <= 1'b0;
                dac_din    <= start_word[15];
                busy       <= 1'b1;
                bitcnt     <= 4'd15;
                tmr        <= TW'(CS_SETUP - 1);
                state      <= SETUP;
                pend_valid <= 1'b0;
            end else begin
                // Outside IDLE and the final GAP cycle a request only lands
                // in the pending slot; the shift register is left alone.
                if (set_en && (state != IDLE)) begin
                    pend_word  <= da_count;
                    pend_valid <= 1'b1;
                    if (pend_valid && (ovr_cnt != 8'hFF)) begin
                        ovr_cnt <= ovr_cnt + 8'd1;
                    end
                end
                case (state)
                    IDLE: begin
                        tmr <= '0;
                    end
                    SETUP: begin
                        if (tmr == '0) begin
                            dac_sclk <= 1'b0;
                            tmr      <= TW'(SCLK_HALF - 1);
                            state    <= SHIFT;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (tmr != '0) begin
                            tmr <= tmr - 1'b1;
                        end else if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                            tmr      <= TW'(SCLK_HALF - 1);
                        end else if (bitcnt != 4'd0) begin
                            // din moves together with the falling edge, so
                            // it only ever changes while sclk is still high.
                            dac_din  <= shreg[bitcnt - 4'd1];
                            bitcnt   <= bitcnt - 4'd1;
                            dac_sclk <= 1'b0;
                            tmr      <= TW'(SCLK_HALF - 1);
                        end else begin
                            tmr   <= TW'(CS_HOLD - 1);
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (tmr == '0) begin
                            dac_cs_n  <= 1'b1;
                            done      <= 1'b1;
                            last_word <= shreg;
                            frame_cnt <= frame_cnt + 8'd1;
                            tmr       <= TW'(CS_GAP - 1);
                            state     <= GAP;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    GAP: begin
                        if (tmr == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apd_hv_dac_spi.sv
// Bench for apd_hv_dac_spi: a timeline model derived from frame offsets,
// an SPI-side capture of each shifted word, and directed scenarios.
`timescale 1ns/1ps
module tb_apd_hv_dac_spi;

    localparam int SETUP = 4;
    localparam int SH    = 10;
    localparam int HOLD  = 4;
    localparam int GAP   = 8;
    localparam int FRAME = SETUP + 32*SH + HOLD;   // 328
    localparam int SPAN  = FRAME + GAP;            // 336

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_en = 1'b0;
    logic [15:0] da_count = '0;
    logic        busy, done, dac_cs_n, dac_sclk, dac_din;
    logic [15:0] last_word;
    logic [7:0]  frame_cnt, ovr_cnt;

    apd_hv_dac_spi #(
        .SCLK_HALF(SH),
        .CS_SETUP (SETUP),
        .CS_HOLD  (HOLD),
        .CS_GAP   (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .da_count (da_count),
        .busy     (busy),
        .done     (done),
        .last_word(last_word),
        .frame_cnt(frame_cnt),
        .ovr_cnt  (ovr_cnt),
        .dac_cs_n (dac_cs_n),
        .dac_sclk (dac_sclk),
        .dac_din  (dac_din)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (frame-offset timeline) ----------------
    bit          m_act = 0;
    int          m_a = 0;
    logic [15:0] m_w = '0, m_pw = '0, m_last = '0;
    bit          m_pv = 0;
    logic [7:0]  m_frames = '0, m_ovr = '0;
    logic        m_lastdin = 1'b0;
    logic [15:0] exp_q[$];
    logic e_cs = 1'b1, e_sclk = 1'b1, e_din = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    task automatic m_reset();
        m_act = 0; m_pv = 0; m_pw = '0; m_w = '0; m_last = '0;
        m_frames = '0; m_ovr = '0; m_lastdin = 1'b0;
        exp_q.delete();
        e_cs = 1'b1; e_sclk = 1'b1; e_din = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    endtask

    task automatic m_start(input logic [15:0] w);
        m_act = 1; m_a = cyc; m_w = w;
        exp_q.push_back(w);
    endtask

    task automatic m_step();
        int t;
        int idx;
        cyc++;
        if (!m_act) begin
            if (set_en) m_start(da_count);
        end else begin
            t = cyc - m_a;
            if (t == FRAME) begin
                m_frames = m_frames + 8'd1;
                m_last = m_w;
                m_lastdin = m_w[0];
            end
            if (t == SPAN) begin
                if (set_en) begin m_start(da_count); m_pv = 0; end
                else if (m_pv) begin m_start(m_pw); m_pv = 0; end
                else m_act = 0;
            end else if (set_en) begin
                if (m_pv && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
                m_pv = 1; m_pw = da_count;
            end
        end
        if (!m_act) begin
            e_cs = 1'b1; e_sclk = 1'b1; e_din = m_lastdin; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            t = cyc - m_a;
            e_busy = 1'b1;
            e_done = (t == FRAME);
            if (t < FRAME) begin
                e_cs = 1'b0;
                if (t < SETUP || t >= SETUP + 32*SH) e_sclk = 1'b1;
                else e_sclk = (((t - SETUP) / SH) % 2) == 1;
                idx = (t < SETUP + 2*SH) ? 0 : (t - SETUP) / (2*SH);
                if (idx > 15) idx = 15;
                e_din = m_w[15 - idx];
            end else begin
                e_cs = 1'b1; e_sclk = 1'b1; e_din = m_w[0];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("outputs",
                {dac_cs_n, dac_sclk, dac_din, busy, done, last_word, frame_cnt, ovr_cnt},
                {e_cs, e_sclk, e_din, e_busy, e_done, m_last, m_frames, m_ovr});
        end
    end

    // ---------------- SPI-side capture ----------------
    logic        p_cs = 1'b1, p_sclk = 1'b1, p_din = 1'b0, p_busy = 1'b0;
    bit          p_rst = 0, in_fr = 0;
    int          nbits = 0;
    logic [15:0] sw = '0, spi_word = '0, ew;
    int cs_fall_cyc = 0, cs_rise_cyc = 0, gap_len = 0, done_cyc = 0, done_cnt = 0;
    int busy_fall_cyc = 0, busy_drops = 0, frames_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_cs = 1'b1; p_sclk = 1'b1; p_din = 1'b0; p_busy = 1'b0;
                p_rst = 0; in_fr = 0; nbits = 0;
            end else begin
                if (p_rst && dac_din !== p_din) chk("din_changes_sclk_high", p_sclk, 1'b1);
                if (p_cs && !dac_cs_n) begin
                    in_fr = 1; nbits = 0; sw = '0;
                    gap_len = cyc - cs_rise_cyc;
                    cs_fall_cyc = cyc;
                end
                if (!dac_cs_n && p_sclk && !dac_sclk) begin
                    sw = {sw[14:0], dac_din};
                    nbits++;
                end
                if (!p_cs && dac_cs_n && in_fr) begin
                    in_fr = 0; cs_rise_cyc = cyc; frames_seen++;
                    spi_word = sw;
                    chk("spi_frame_expected", exp_q.size() != 0, 1'b1);
                    ew = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                    chk("spi_word_bits", {nbits[7:0], sw}, {8'd16, ew});
                end
                if (done) begin done_cyc = cyc; done_cnt++; end
                if (p_busy && !busy) begin busy_fall_cyc = cyc; busy_drops++; end
                p_cs = dac_cs_n; p_sclk = dac_sclk; p_din = dac_din; p_busy = busy;
                p_rst = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic [15:0] w);
        set_en = 1'b1; da_count = w;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    int d0, f0, a0;
    logic [15:0] w6;

    initial begin
        wait_n(3);
        chk("reset_link", {dac_cs_n, dac_sclk, dac_din}, 3'b110);
        chk("reset_status", {busy, done}, 2'b00);
        chk("reset_regs", {last_word, frame_cnt, ovr_cnt}, 32'h0);
        rst_n = 1'b1;
        wait_n(5);

        // single write
        req(16'h8A28);
        wait_n(345);
        chk("t1_spi_word", spi_word, 16'h8A28);
        chk("t1_cs_low_len", cs_rise_cyc - cs_fall_cyc, 328);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_last_word", last_word, 16'h8A28);
        chk("t1_frame_cnt", frame_cnt, 8'd1);
        chk("t1_busy_tail", busy_fall_cyc - done_cyc, 8);

        // back-to-back via the pending slot
        d0 = busy_drops; f0 = frames_seen;
        req(16'h8FFC);
        wait_n(49);
        req(16'h8004);
        wait_n(640);
        chk("t2_spi_word", spi_word, 16'h8004);
        chk("t2_gap_len", gap_len, 8);
        chk("t2_busy_drops", busy_drops - d0, 1);
        chk("t2_frames", frames_seen - f0, 2);
        chk("t2_ovr", ovr_cnt, 8'd0);
        chk("t2_frame_cnt", frame_cnt, 8'd3);

        // overwrites: latest wins
        f0 = frames_seen;
        req(16'h8001);
        wait_n(20); req(16'h8100);
        wait_n(20); req(16'h8200);
        wait_n(20); req(16'h8300);
        wait_n(700);
        chk("t3_spi_word", spi_word, 16'h8300);
        chk("t3_ovr", ovr_cnt, 8'd2);
        chk("t3_frames", frames_seen - f0, 2);
        chk("t3_frame_cnt", frame_cnt, 8'd5);
        chk("t3_idle", busy, 1'b0);

        // request in the final GAP cycle beats the pending word
        f0 = frames_seen;
        req(16'h8010);
        a0 = cs_fall_cyc;
        wait_n(99);
        req(16'h8020);
        while (cyc < a0 + SPAN - 1) @(negedge clk);
        req(16'h8040);
        wait_n(400);
        chk("t4_spi_word", spi_word, 16'h8040);
        chk("t4_gap_len", gap_len, 8);
        chk("t4_frames", frames_seen - f0, 2);
        chk("t4_frame_cnt", frame_cnt, 8'd7);
        chk("t4_idle", busy, 1'b0);
        chk("t4_ovr", ovr_cnt, 8'd2);

        // reset in the middle of SHIFT
        f0 = frames_seen;
        req(16'h8A5F);
        wait_n(95);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_link_async", {dac_cs_n, dac_sclk, dac_din}, 3'b110);
        chk("t5_busy_async", busy, 1'b0);
        chk("t5_regs_async", {last_word, frame_cnt, ovr_cnt}, 32'h0);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(3);
        req(16'h8555);
        wait_n(345);
        chk("t5_spi_word", spi_word, 16'h8555);
        chk("t5_last_word", last_word, 16'h8555);
        chk("t5_frame_cnt", frame_cnt, 8'd1);
        chk("t5_frames", frames_seen - f0, 1);

        // frame counter wrap: 255 more frames after the one above
        f0 = frames_seen;
        for (int i = 1; i <= 255; i++) begin
            w6 = 16'h8000 | 16'(i << 2);
            req(w6);
            wait_n(338);
        end
        chk("t6_frame_cnt_wrap", frame_cnt, 8'd0);
        chk("t6_last_word", last_word, 16'h83FC);
        chk("t6_spi_word", spi_word, 16'h83FC);
        chk("t6_frames", frames_seen - f0, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
